control_sequencer: RTL and testbench

- Hardwired control unit that replaces the hand-scripted per-step stimulus used to drive the datapath.
- Runs fetch (T0–T2) and then an opcode-dependent execute sequence (T3–T7). It emits one-hot bus-source selects, register enables, select-and-encode controls and the ALU op for every step.
- Generalised over the older fixed ld-only sequence:
  - parametrised widths;
  - a memory ready handshake with a bounded wait;
  - several instruction classes;
  - a run/halt mode.

---
 rtl/cs_pkg.sv | 94 +++++++++
 rtl/cs_mem_wait.sv | 25 ++
 rtl/control_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared types and constants for the control sequencer.
// Build option MUL_DIV_EN makes opcodes 14 (mul) and 15 (div) legal.
package cs_pkg;

    typedef enum logic [3:0] {
        S_T0   = 4'h0,
        S_T1   = 4'h1,
        S_T2   = 4'h2,
        S_T3   = 4'h3,
        S_T4   = 4'h4,
        S_T5   = 4'h5,
        S_T6   = 4'h6,
        S_T7   = 4'h7,
        S_HALT = 4'h8,
        S_IDLE = 4'hF
    } state_t;

    typedef enum logic [3:0] {
        C_LD,
        C_LDI,
        C_ST,
        C_ALU,
        C_ALUI,
        C_MULDIV,
        C_BR,
        C_HALT,
        C_ILLEGAL
    } cls_t;

    localparam int unsigned OP_LD   = 0;
    localparam int unsigned OP_LDI  = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_ADD  = 3;
    localparam int unsigned OP_ROL  = 10;
    localparam int unsigned OP_ADDI = 11;
    localparam int unsigned OP_ANDI = 12;
    localparam int unsigned OP_ORI  = 13;
    localparam int unsigned OP_MUL  = 14;
    localparam int unsigned OP_DIV  = 15;
    localparam int unsigned OP_BR   = 18;
    localparam int unsigned OP_HALT = 27;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_SHR = 4;
    localparam int unsigned ALU_SHL = 5;
    localparam int unsigned ALU_ROR = 6;
    localparam int unsigned ALU_ROL = 7;
    localparam int unsigned ALU_MUL = 8;
    localparam int unsigned ALU_DIV = 9;

    localparam int unsigned REG_HI   = 16;
    localparam int unsigned REG_LO   = 17;
    localparam int unsigned REG_ZHI  = 18;
    localparam int unsigned REG_ZLOW = 19;
    localparam int unsigned REG_PC   = 20;
    localparam int unsigned REG_IR   = 21;
    localparam int unsigned REG_MDR  = 22;
    localparam int unsigned REG_MAR  = 23;
    localparam int unsigned REG_Y    = 24;
    localparam int unsigned REG_C    = 25;

    // Map an opcode onto the execute sequence it uses.
    function automatic cls_t classify(input int unsigned op);
        cls_t c;
        c = C_ILLEGAL;
        if (op == OP_LD)                         c = C_LD;
        else if (op == OP_LDI)                   c = C_LDI;
        else if (op == OP_ST)                    c = C_ST;
        else if (op >= OP_ADD && op <= OP_ROL)   c = C_ALU;
        else if (op >= OP_ADDI && op <= OP_ORI)  c = C_ALUI;
        else if (op == OP_BR)                    c = C_BR;
        else if (op == OP_HALT)                  c = C_HALT;
`ifdef MUL_DIV_EN
        else if (op == OP_MUL || op == OP_DIV)   c = C_MULDIV;
`endif
        return c;
    endfunction

    // ALU operation used by the instruction's arithmetic step.
    function automatic int unsigned alu_op(input int unsigned op);
        int unsigned a;
        a = ALU_ADD;
        if (op >= OP_ADD && op <= OP_ROL) a = op - OP_ADD;
        else if (op == OP_ANDI)           a = ALU_AND;
        else if (op == OP_ORI)            a = ALU_OR;
        else if (op == OP_MUL)            a = ALU_MUL;
        else if (op == OP_DIV)            a = ALU_DIV;
        return a;
    endfunction

endpackage

// File: rtl/cs_mem_wait.sv
// Memory-ready wait counter; flags a timeout on the last allowed wait cycle.
module cs_mem_wait #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic clr,
    input  logic active,
    input  logic mem_rdy,
    output logic timeout_c
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Counts held cycles; clears whenever the step is left or completes.
    always_ff @(posedge clock or posedge clr) begin
        if (clr)                     cnt <= '0;
        else if (!active || mem_rdy) cnt <= '0;
        else                         cnt <= cnt + CNT_W'(1);
    end

    assign timeout_c = active && !mem_rdy && (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control sequencer with Moore-decoded datapath controls.
// Build option MUL_DIV_EN (see cs_pkg) enables the mul/div execute sequence.
module control_sequencer
    import cs_pkg::*;
#(
    parameter int unsigned SEL_W       = 32,
    parameter int unsigned OPC_W       = 5,
    parameter int unsigned ALU_W       = 6,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_rdy,
    input  logic             con_ff,
    output logic [SEL_W-1:0] enc_sel,
    output logic [SEL_W-1:0] reg_en,
    output logic             inc_pc,
    output logic             read,
    output logic             write,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             r_in,
    output logic             r_out,
    output logic             ba_out,
    output logic             con_in,
    output logic [ALU_W-1:0] alu_sel,
    output logic [3:0]       step,
    output logic             halted,
    output logic             fault
);

    state_t           state, state_d;
    cls_t             cls_q, dec_c;
    logic [ALU_W-1:0] alu_q;
    logic             con_q;
    logic             fault_q, fault_d;
    logic             mem_active_c, timeout_c;
    state_t           done_c;

    function automatic logic [SEL_W-1:0] bit_of(input int unsigned idx);
        return SEL_W'(1) << idx;
    endfunction

    assign dec_c  = classify(32'(opcode));
    assign done_c = run ? S_T0 : S_IDLE;
    assign mem_active_c = (state == S_T1)
                       || (state == S_T6 && cls_q == C_LD)
                       || (state == S_T7 && cls_q == C_ST);

    cs_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
        .clock     (clock),
        .clr       (clr),
        .active    (mem_active_c),
        .mem_rdy   (mem_rdy),
        .timeout_c (timeout_c)
    );

    // State, latched instruction class, and the branch condition sampled before T6.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            cls_q   <= C_LD;
            alu_q   <= '0;
            con_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_d;
            fault_q <= fault_d;
            if (state == S_T2) begin
                cls_q <= dec_c;
                alu_q <= ALU_W'(alu_op(32'(opcode)));
            end
            if (state == S_T5) con_q <= con_ff;
        end
    end

    always_comb begin
        state_d = state;
        fault_d = fault_q;
        case (state)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (mem_rdy)        state_d = S_T2;
                else if (timeout_c) begin state_d = S_HALT; fault_d = 1'b1; end
            end
            S_T2: begin
                if (dec_c == C_ILLEGAL)   begin state_d = S_HALT; fault_d = 1'b1; end
                else if (dec_c == C_HALT) state_d = S_HALT;
                else                      state_d = S_T3;
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls_q == C_LDI || cls_q == C_ALU || cls_q == C_ALUI) state_d = done_c;
                else                                                     state_d = S_T6;
            end
            S_T6: begin
                if (cls_q == C_ST) state_d = S_T7;
                else if (cls_q == C_LD) begin
                    if (mem_rdy)        state_d = S_T7;
                    else if (timeout_c) begin state_d = S_HALT; fault_d = 1'b1; end
                end else state_d = done_c;
            end
            S_T7: begin
                if (cls_q != C_ST || mem_rdy) state_d = done_c;
                else if (timeout_c)           begin state_d = S_HALT; fault_d = 1'b1; end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign step   = state;
    assign halted = (state == S_HALT);
    assign fault  = fault_q;

    // Per-step control decode; depends only on state and latched instruction.
    always_comb begin
        enc_sel = '0;
        reg_en  = '0;
        inc_pc  = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        r_in    = 1'b0;
        r_out   = 1'b0;
        ba_out  = 1'b0;
        con_in  = 1'b0;
        alu_sel = '0;
        case (state)
            S_T0: begin
                enc_sel = bit_of(REG_PC);
                reg_en  = bit_of(REG_MAR) | bit_of(REG_ZLOW);
                inc_pc  = 1'b1;
            end
            S_T1: begin
                enc_sel = bit_of(REG_ZLOW);
                reg_en  = bit_of(REG_PC) | bit_of(REG_MDR);
                read    = 1'b1;
            end
            S_T2: begin
                enc_sel = bit_of(REG_MDR);
                reg_en  = bit_of(REG_IR);
            end
            S_T3: begin
                case (cls_q)
                    C_MULDIV: begin gra = 1'b1; r_out = 1'b1; reg_en = bit_of(REG_Y); end
                    C_BR:     begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
                    default:  begin grb = 1'b1; r_out = 1'b1; reg_en = bit_of(REG_Y); end
                endcase
            end
            S_T4: begin
                case (cls_q)
                    C_ALU: begin
                        grc = 1'b1; r_out = 1'b1; alu_sel = alu_q; reg_en = bit_of(REG_ZLOW);
                    end
                    C_ALUI: begin
                        enc_sel = bit_of(REG_C); alu_sel = alu_q; reg_en = bit_of(REG_ZLOW);
                    end
                    C_MULDIV: begin
                        grb = 1'b1; r_out = 1'b1; alu_sel = alu_q; reg_en = bit_of(REG_ZLOW);
                    end
                    C_BR: begin
                        enc_sel = bit_of(REG_PC); reg_en = bit_of(REG_Y);
                    end
                    default: begin
                        enc_sel = bit_of(REG_C); alu_sel = ALU_W'(ALU_ADD); reg_en = bit_of(REG_ZLOW);
                    end
                endcase
            end
            S_T5: begin
                case (cls_q)
                    C_LD, C_ST: begin enc_sel = bit_of(REG_ZLOW); reg_en = bit_of(REG_MAR); end
                    C_MULDIV:   begin enc_sel = bit_of(REG_ZLOW); reg_en = bit_of(REG_LO); end
                    C_BR: begin
                        enc_sel = bit_of(REG_C); alu_sel = ALU_W'(ALU_ADD); reg_en = bit_of(REG_ZLOW);
                    end
                    default: begin enc_sel = bit_of(REG_ZLOW); gra = 1'b1; r_in = 1'b1; end
                endcase
            end
            S_T6: begin
                case (cls_q)
                    C_LD:     begin read = 1'b1; reg_en = bit_of(REG_MDR); end
                    C_ST:     begin gra = 1'b1; r_out = 1'b1; reg_en = bit_of(REG_MDR); end
                    C_MULDIV: begin enc_sel = bit_of(REG_ZHI); reg_en = bit_of(REG_HI); end
                    C_BR: begin
                        enc_sel = bit_of(REG_ZLOW);
                        if (con_q) reg_en = bit_of(REG_PC);
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls_q)
                    C_LD:    begin enc_sel = bit_of(REG_MDR); gra = 1'b1; r_in = 1'b1; end
                    C_ST:    write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer; expectations queued at drive time.
module tb_control_sequencer;

    localparam int unsigned SEL_W = 32;
    localparam int unsigned OPC_W = 5;
    localparam int unsigned ALU_W = 6;
    localparam int unsigned MEM_TIMEOUT = 15;

    localparam int C_INC = 9, C_RD = 8, C_WR = 7, C_GRA = 6, C_GRB = 5;
    localparam int C_GRC = 4, C_RIN = 3, C_ROUT = 2, C_BA = 1, C_CON = 0;

    logic             clock, clr, run, mem_rdy, con_ff;
    logic [OPC_W-1:0] opcode;
    logic [SEL_W-1:0] enc_sel, reg_en;
    logic             inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out, con_in;
    logic [ALU_W-1:0] alu_sel;
    logic [3:0]       step;
    logic             halted, fault;

    typedef struct packed {
        logic [3:0]  step;
        logic [31:0] enc;
        logic [31:0] ren;
        logic [5:0]  alu;
        logic [9:0]  ctl;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t  obs;
    exp_t  sb[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    control_sequencer #(
        .SEL_W(SEL_W), .OPC_W(OPC_W), .ALU_W(ALU_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock(clock), .clr(clr), .run(run), .opcode(opcode), .mem_rdy(mem_rdy),
        .con_ff(con_ff), .enc_sel(enc_sel), .reg_en(reg_en), .inc_pc(inc_pc),
        .read(read), .write(write), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
        .r_out(r_out), .ba_out(ba_out), .con_in(con_in), .alu_sel(alu_sel),
        .step(step), .halted(halted), .fault(fault)
    );

    assign obs = {step, enc_sel, reg_en, alu_sel,
                  inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out, con_in,
                  halted, fault};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] b(input int n);
        return 32'(1) << n;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.step = 4'hF;
        return e;
    endfunction

    function automatic exp_t halt_exp(input bit f);
        exp_t e;
        e = '0;
        e.step = 4'h8;
        e.halted = 1'b1;
        e.fault = f;
        return e;
    endfunction

    // Expected controls for step t of opcode opc, taken from the step tables.
    function automatic exp_t ref_out(input int opc, input int t, input bit con);
        exp_t e;
        bit ld, ldi, st, alr, ali, md, br;
        ld  = (opc == 0);
        ldi = (opc == 1);
        st  = (opc == 2);
        alr = (opc >= 3 && opc <= 10);
        ali = (opc >= 11 && opc <= 13);
        md  = (opc == 14 || opc == 15);
        br  = (opc == 18);
        e = '0;
        e.step = 4'(t);
        case (t)
            0: begin e.enc = b(20); e.ren = b(23) | b(19); e.ctl[C_INC] = 1'b1; end
            1: begin e.enc = b(19); e.ren = b(20) | b(22); e.ctl[C_RD] = 1'b1; end
            2: begin e.enc = b(22); e.ren = b(21); end
            3: begin
                if (md || br) e.ctl[C_GRA] = 1'b1; else e.ctl[C_GRB] = 1'b1;
                e.ctl[C_ROUT] = 1'b1;
                if (br) e.ctl[C_CON] = 1'b1; else e.ren = b(24);
            end
            4: begin
                if (ld || ldi || st) begin e.enc = b(25); e.ren = b(19); end
                if (alr) begin e.ctl[C_GRC] = 1'b1; e.ctl[C_ROUT] = 1'b1; e.alu = 6'(opc - 3); e.ren = b(19); end
                if (ali) begin e.enc = b(25); e.alu = (opc == 11) ? 6'd0 : (opc == 12) ? 6'd2 : 6'd3; e.ren = b(19); end
                if (md)  begin e.ctl[C_GRB] = 1'b1; e.ctl[C_ROUT] = 1'b1; e.alu = (opc == 14) ? 6'd8 : 6'd9; e.ren = b(19); end
                if (br)  begin e.enc = b(20); e.ren = b(24); end
            end
            5: begin
                if (ld || st) begin e.enc = b(19); e.ren = b(23); end
                if (ldi || alr || ali) begin e.enc = b(19); e.ctl[C_GRA] = 1'b1; e.ctl[C_RIN] = 1'b1; end
                if (md) begin e.enc = b(19); e.ren = b(17); end
                if (br) begin e.enc = b(25); e.ren = b(19); end
            end
            6: begin
                if (ld) begin e.ctl[C_RD] = 1'b1; e.ren = b(22); end
                if (st) begin e.ctl[C_GRA] = 1'b1; e.ctl[C_ROUT] = 1'b1; e.ren = b(22); end
                if (md) begin e.enc = b(18); e.ren = b(16); end
                if (br) begin e.enc = b(19); if (con) e.ren = b(20); end
            end
            7: begin
                if (ld) begin e.enc = b(22); e.ctl[C_GRA] = 1'b1; e.ctl[C_RIN] = 1'b1; end
                if (st) e.ctl[C_WR] = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_pop();
        exp_t  e;
        string tg;
        e  = sb.pop_front();
        tg = tag_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tg, obs, e);
        end
    endtask

    // Queue the expectation for the state after the next edge, then compare.
    task automatic exp_next(input string tag, input exp_t e);
        sb.push_back(e);
        tag_q.push_back(tag);
        @(negedge clock);
        check_pop();
    endtask

    // Compare without a clock edge (asynchronous reset effect).
    task automatic exp_now(input string tag, input exp_t e);
        sb.push_back(e);
        tag_q.push_back(tag);
        #1;
        check_pop();
    endtask

    task automatic run_steps(input string tag, input int opc, input bit con,
                             input int t_from, input int t_to);
        for (int t = t_from; t <= t_to; t++)
            exp_next($sformatf("%s_t%0d", tag, t), ref_out(opc, t, con));
    endtask

    task automatic reset_restart(input string tag);
        clr = 1'b1;
        exp_now(tag, idle_exp());
        @(negedge clock);
        clr = 1'b0;
        run = 1'b1;
        mem_rdy = 1'b1;
        exp_next({tag, "_t0"}, ref_out(0, 0, 1'b0));
    endtask

    initial begin
        clr = 1'b1; run = 1'b0; mem_rdy = 1'b1; con_ff = 1'b0; opcode = '0;
        repeat (2) @(negedge clock);
        exp_now("reset", idle_exp());
        clr = 1'b0;
        run = 1'b1;
        exp_next("first_t0", ref_out(0, 0, 1'b0));

        opcode = 5'd0;
        run_steps("ld", 0, 1'b0, 1, 7);
        exp_next("ld_next", ref_out(0, 0, 1'b0));

        opcode = 5'd3;
        mem_rdy = 1'b0;
        run_steps("add_wait_c1", 3, 1'b0, 1, 1);
        run_steps("add_wait_c2", 3, 1'b0, 1, 1);
        run_steps("add_wait_c3", 3, 1'b0, 1, 1);
        run_steps("add_wait_c4", 3, 1'b0, 1, 1);
        mem_rdy = 1'b1;
        run_steps("add", 3, 1'b0, 2, 5);
        exp_next("add_next", ref_out(0, 0, 1'b0));

        opcode = 5'd18; con_ff = 1'b0;
        run_steps("br_false", 18, 1'b0, 1, 6);
        exp_next("br_false_next", ref_out(0, 0, 1'b0));
        con_ff = 1'b1;
        run_steps("br_true", 18, 1'b1, 1, 6);
        exp_next("br_true_next", ref_out(0, 0, 1'b0));
        con_ff = 1'b0;

        opcode = 5'd12;
        run_steps("andi", 12, 1'b0, 1, 5);
        exp_next("andi_next", ref_out(0, 0, 1'b0));

        opcode = 5'd1;
        run_steps("ldi", 1, 1'b0, 1, 3);
        run = 1'b0;
        run_steps("ldi_norun", 1, 1'b0, 4, 5);
        exp_next("ldi_idle", idle_exp());
        run = 1'b1;
        exp_next("idle_to_t0", ref_out(0, 0, 1'b0));

        opcode = 5'd0;
        run_steps("ld_abort", 0, 1'b0, 1, 4);
        reset_restart("clr_mid_t4");

        opcode = 5'd14;
`ifdef MUL_DIV_EN
        run_steps("mul", 14, 1'b0, 1, 6);
        exp_next("mul_next", ref_out(0, 0, 1'b0));
`else
        run_steps("mul_off", 14, 1'b0, 1, 2);
        exp_next("mul_illegal", halt_exp(1'b1));
        reset_restart("mul_clr");
`endif

        opcode = 5'd20;
        run_steps("illegal", 20, 1'b0, 1, 2);
        exp_next("illegal_halt", halt_exp(1'b1));
        exp_next("illegal_stay", halt_exp(1'b1));
        reset_restart("illegal_clr");

        opcode = 5'd27;
        run_steps("halt", 27, 1'b0, 1, 2);
        exp_next("halt_state", halt_exp(1'b0));
        reset_restart("halt_clr");

        opcode = 5'd2;
        run_steps("st", 2, 1'b0, 1, 6);
        mem_rdy = 1'b0;
        for (int i = 1; i <= 15; i++)
            exp_next($sformatf("st_wait_c%0d", i), ref_out(2, 7, 1'b0));
        exp_next("st_timeout", halt_exp(1'b1));
        exp_next("st_halt_stay", halt_exp(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
